// File: rtl/rr_grant_ctrl4.sv
// Round-robin arbiter for one shared resource and four requesters.
// Owners hold the grant until they release it or drop their request; a hold
// timer forces rotation when an owner keeps the resource while others wait.
// All outputs are registered. gnt_o is always the decode of gnt_idx_o gated by
// gnt_valid_o, so it is one-hot or zero.
module rr_grant_ctrl4 #(
  parameter int unsigned MAX_HOLD = 8  // 0 = no limit, legal 0..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       rel_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       expired_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Hold count at which a waiting requester forces rotation.
  localparam logic [3:0] HOLD_LAST = (MAX_HOLD == 0) ? 4'd0 : 4'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [3:0] gnt_q, gnt_d;
  logic       expired_q, expired_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] last_q, last_d;

  // Round-robin pick: search starts just after base, so base itself is checked
  // last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    // Walk from lowest to highest priority so the highest-priority hit wins.
    for (int k = 4; k >= 1; k--) begin
      cand = base + 2'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [3:0] owner_dec;
  logic       owner_drop;
  logic       others_wait;
  logic       timeout;
  logic       release_now;
  logic [3:0] pick_req;
  logic [2:0] pick;

  // Release conditions and next-state selection for the arbiter.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    gnt_d       = gnt_q;
    expired_d   = 1'b0;
    hold_d      = hold_q;
    last_d      = last_q;
    owner_dec   = 4'b0001 << idx_q;
    owner_drop  = ~req_i[idx_q];
    others_wait = |(req_i & ~owner_dec);
    timeout     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_wait;
    release_now = rel_i | owner_drop | timeout;
    pick_req    = req_i;
    pick        = 3'b000;

    case (state_q)
      IDLE: begin
        pick = rr_pick(req_i, last_q);
        if (pick[2]) begin
          state_d = GRANT;
          idx_d   = pick[1:0];
          valid_d = 1'b1;
          gnt_d   = 4'b0001 << pick[1:0];
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_d = idx_q;
          if (owner_drop) pick_req = req_i & ~owner_dec;
          pick   = rr_pick(pick_req, idx_q);
          hold_d = 4'd0;
          if (pick[2]) begin
            idx_d = pick[1:0];
            gnt_d = 4'b0001 << pick[1:0];
            // rel and an owner drop take precedence over the timer.
            expired_d = timeout & ~rel_i & ~owner_drop;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = 4'b0000;
          end
        end else if (hold_q != 4'd15) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        gnt_d   = 4'b0000;
        hold_d  = 4'd0;
      end
    endcase
  end

  // State registers; reset drops any grant and restores requester 0 priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'b00;
      valid_q   <= 1'b0;
      gnt_q     <= 4'b0000;
      expired_q <= 1'b0;
      hold_q    <= 4'd0;
      last_q    <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      gnt_q     <= gnt_d;
      expired_q <= expired_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign expired_o   = expired_q;

endmodule

// File: tb/tb_rr_grant_ctrl4.sv
// Self-checking bench for rr_grant_ctrl4: directed scenarios followed by
// randomized traffic, compared each cycle against a behavioural model.
module tb_rr_grant_ctrl4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  rr_grant_ctrl4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .rel_i       (rel),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .expired_o   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the resource, who owned it last, and for how
  // many cycles the current owner has held it.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;
  bit m_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [3:0] r, input int base);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (base + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = 3;
    m_held  = 0;
    m_exp   = 0;
  endtask

  // Advance the model by one clock edge using the inputs in force at that edge.
  task automatic model_step();
    bit drop, others, tmo;
    int w;
    logic [3:0] cand;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_exp = 0;
    if (!m_busy) begin
      w = rr_first(req, m_last);
      if (w >= 0) begin
        m_busy  = 1;
        m_owner = w;
        m_held  = 0;
      end
    end else begin
      drop   = !req[m_owner];
      cand   = req;
      cand[m_owner] = 1'b0;
      others = (cand != 4'b0000);
      tmo    = (MAX_HOLD != 0) && (m_held == MAX_HOLD - 1) && others;
      if (rel || drop || tmo) begin
        m_last = m_owner;
        w = rr_first(drop ? cand : req, m_owner);
        m_held = 0;
        if (w >= 0) begin
          m_owner = w;
          m_exp   = tmo && !rel && !drop;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_held = (m_held + 1 > 15) ? 15 : m_held + 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(m_busy));
    check({tag, ".expired"}, 32'(expired), 32'(m_exp));
    if (m_busy) check({tag, ".idx"}, 32'(gnt_idx), 32'(m_owner));
  endtask

  // Drive inputs at the falling edge, step the model at the rising edge and
  // sample the DUT at the following falling edge.
  task automatic tick(input logic [3:0] r, input logic rl, input string tag);
    req = r;
    rel = rl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    check({tag, ".idx_rst"}, 32'(gnt_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic       rl;

    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held low while req toggles: nothing may be granted.
    tick(4'b1111, 1'b0, "rst_hold");
    tick(4'b0101, 1'b1, "rst_hold");
    check("rst.idx", 32'(gnt_idx), 32'd0);
    rst_n = 1'b1;
    tick(4'b0000, 1'b0, "rst_idle");
    tick(4'b0000, 1'b1, "rst_idle_rel");

    // Request-to-grant latency of one edge.
    tick(4'b0001, 1'b0, "latency");
    check("latency.gnt_const", 32'(gnt), 32'h1);
    tick(4'b0000, 1'b0, "latency_drop");

    // Full rotation with a rel pulse every cycle, no idle gaps.
    async_reset("rot_rst");
    tick(4'b1111, 1'b0, "rot0");
    check("rot.g0", 32'(gnt), 32'h1);
    tick(4'b1111, 1'b1, "rot1");
    check("rot.g1", 32'(gnt), 32'h2);
    tick(4'b1111, 1'b1, "rot2");
    check("rot.g2", 32'(gnt), 32'h4);
    tick(4'b1111, 1'b1, "rot3");
    check("rot.g3", 32'(gnt), 32'h8);
    tick(4'b1111, 1'b1, "rot4");
    check("rot.g4", 32'(gnt), 32'h1);

    // Timeout: requester 0 keeps the grant for MAX_HOLD cycles, then 1 takes over.
    async_reset("tmo_rst");
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick(4'b0011, 1'b0, "tmo_hold");
      check("tmo.hold_gnt", 32'(gnt), 32'h1);
      check("tmo.hold_exp", 32'(expired), 32'h0);
    end
    tick(4'b0011, 1'b0, "tmo_swap");
    check("tmo.swap_gnt", 32'(gnt), 32'h2);
    check("tmo.swap_exp", 32'(expired), 32'h1);
    tick(4'b0011, 1'b0, "tmo_after");
    check("tmo.after_exp", 32'(expired), 32'h0);

    // Timeout and rel together count as an ordinary release.
    async_reset("tmo_rel_rst");
    for (int i = 0; i < MAX_HOLD; i++) tick(4'b0011, 1'b0, "tmo_rel_hold");
    tick(4'b0011, 1'b1, "tmo_rel");
    check("tmo_rel.exp", 32'(expired), 32'h0);

    // Sole owner is never timed out.
    async_reset("sole_rst");
    for (int i = 0; i < 40; i++) begin
      tick(4'b0100, 1'b0, "sole");
      check("sole.gnt", 32'(gnt), 32'h4);
    end
    tick(4'b0000, 1'b0, "sole_drop");
    check("sole.drop_gnt", 32'(gnt), 32'h0);

    // Async reset mid-grant, then requester 0 has priority again.
    async_reset("mid_rst0");
    tick(4'b1000, 1'b0, "mid_grant");
    check("mid.gnt", 32'(gnt), 32'h8);
    req = 4'b1001;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.async_gnt", 32'(gnt), 32'h0);
    check("mid.async_valid", 32'(gnt_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1001, 1'b0, "mid_after");
    check("mid.first_gnt", 32'(gnt), 32'h1);

    // Randomized traffic; req tends to persist so timeouts and sole-owner
    // saturation both get exercised.
    r = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3, 0) == 0) r = 4'($urandom_range(15, 0));
      rl = ($urandom_range(5, 0) == 0);
      if ($urandom_range(499, 0) == 0) async_reset("rand_rst");
      tick(r, rl, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
